// File: rtl/cpu_exec_pkg.sv
// Shared constants for the execute/memory slice: datapath width, opcode map and ALU function codes.
// The optional ALU status flags are enabled by defining ALU_FLAGS_EN.
package cpu_exec_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_J     = 4'h6;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/cpu_exec_if.sv
// Bundle of decoder/regfile inputs and control/datapath outputs of the execute slice.
// With ALU_FLAGS_EN defined the bundle also carries alu_zero/alu_carry/alu_ovf.
// There is no handshake: every output is a combinational function of the current
// inputs plus the data memory contents, valid whenever the inputs are stable.
interface cpu_exec_if;
    import cpu_exec_pkg::*;

    logic [3:0]        opcode;
    logic [2:0]        func;
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic [DATA_W-1:0] imm;

    logic              reg_dst;
    logic              reg_write;
    logic              alusrc;
    logic [2:0]        alufn;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              nia;
    logic              br;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] mem_out;
    logic [DATA_W-1:0] wb_data;

`ifdef ALU_FLAGS_EN
    logic              alu_zero;
    logic              alu_carry;
    logic              alu_ovf;

    modport master (
        output opcode, func, ra, rb, imm,
        input  reg_dst, reg_write, alusrc, alufn, mem_read, mem_write, mem_to_reg,
        input  nia, br, aluout, mem_out, wb_data, alu_zero, alu_carry, alu_ovf
    );
    modport slave (
        input  opcode, func, ra, rb, imm,
        output reg_dst, reg_write, alusrc, alufn, mem_read, mem_write, mem_to_reg,
        output nia, br, aluout, mem_out, wb_data, alu_zero, alu_carry, alu_ovf
    );
`else
    modport master (
        output opcode, func, ra, rb, imm,
        input  reg_dst, reg_write, alusrc, alufn, mem_read, mem_write, mem_to_reg,
        input  nia, br, aluout, mem_out, wb_data
    );
    modport slave (
        input  opcode, func, ra, rb, imm,
        output reg_dst, reg_write, alusrc, alufn, mem_read, mem_write, mem_to_reg,
        output nia, br, aluout, mem_out, wb_data
    );
`endif

endinterface

// File: rtl/cpu_exec_alu.sv
// Combinational 8-bit ALU with operand-B select and branch compare.
// Status flags (zero/carry/overflow) exist only when ALU_FLAGS_EN is defined.
module cpu_exec_alu
    import cpu_exec_pkg::*;
(
    input  logic [2:0]        alufn,
    input  logic              alusrc,
    input  logic              is_beq,
    input  logic              is_bne,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] rb,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              br
`ifdef ALU_FLAGS_EN
    ,
    output logic              alu_zero,
    output logic              alu_carry,
    output logic              alu_ovf
`endif
);

    logic [DATA_W-1:0] b;

    assign b = alusrc ? imm : rb;

    always_comb begin
        result = '0;
        case (alufn)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: result = a << b[2:0];
            ALU_SRL: result = a >> b[2:0];
            default: result = '0;
        endcase
    end

    // Branches always compare the raw register operands.
    assign br = (is_beq && (a == rb)) || (is_bne && (a != rb));

`ifdef ALU_FLAGS_EN
    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] diff_ext;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alufn)
            ALU_ADD: begin
                alu_carry = sum_ext[DATA_W];
                alu_ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_carry = diff_ext[DATA_W];
                alu_ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            default: begin
                alu_carry = 1'b0;
                alu_ovf   = 1'b0;
            end
        endcase
    end

    assign alu_zero = (result == '0);
`endif

endmodule

// File: rtl/cpu_exec_unit.sv
// Execute/memory slice of the 8-bit single-cycle CPU: control decode, ALU, 256x8 data memory, writeback mux.
// Define ALU_FLAGS_EN to expose alu_zero/alu_carry/alu_ovf on the bus interface.
module cpu_exec_unit
    import cpu_exec_pkg::*;
#(
    parameter int DMEM_AW = 8
)(
    input  logic      clk,
    input  logic      rst,
    cpu_exec_if.slave bus
);

    localparam int DEPTH = 1 << DMEM_AW;

    logic              reg_dst;
    logic              reg_write;
    logic              alusrc;
    logic [2:0]        alufn;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              nia;
    logic              is_beq;
    logic              is_bne;
    logic              br;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] mem_out;
    logic [DMEM_AW-1:0] addr;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_comb begin
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alusrc     = 1'b0;
        alufn      = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        nia        = 1'b1;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        case (bus.opcode)
            OP_RTYPE: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b1;
                alufn      = bus.func;
            end
            OP_ADDI: begin
                reg_write  = 1'b1;
                alusrc     = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_LW: begin
                reg_write = 1'b1;
                alusrc    = 1'b1;
                mem_read  = 1'b1;
            end
            OP_SW: begin
                alusrc    = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                alufn  = ALU_SUB;
                is_beq = 1'b1;
            end
            OP_BNE: begin
                alufn  = ALU_SUB;
                is_bne = 1'b1;
            end
            OP_J:    nia = 1'b0;
            default: ;
        endcase
    end

    cpu_exec_alu u_alu (
        .alufn     (alufn),
        .alusrc    (alusrc),
        .is_beq    (is_beq),
        .is_bne    (is_bne),
        .a         (bus.ra),
        .rb        (bus.rb),
        .imm       (bus.imm),
        .result    (aluout),
        .br        (br)
`ifdef ALU_FLAGS_EN
        ,
        .alu_zero  (bus.alu_zero),
        .alu_carry (bus.alu_carry),
        .alu_ovf   (bus.alu_ovf)
`endif
    );

    assign addr = aluout[DMEM_AW-1:0];

    // Reset wins over a same-cycle store so the memory comes out of reset fully cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_write) begin
            mem_q[addr] <= bus.rb;
        end
    end

    // Asynchronous read gives the pre-edge contents on a read-during-write.
    assign mem_out = mem_read ? mem_q[addr] : '0;

    assign bus.reg_dst    = reg_dst;
    assign bus.reg_write  = reg_write;
    assign bus.alusrc     = alusrc;
    assign bus.alufn      = alufn;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.nia        = nia;
    assign bus.br         = br;
    assign bus.aluout     = aluout;
    assign bus.mem_out    = mem_out;
    assign bus.wb_data    = mem_to_reg ? aluout : mem_out;

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Self-checking bench for cpu_exec_unit: directed steps plus random ALU/memory traffic
// against a reference model of decode, ALU and data memory.
module tb_cpu_exec_unit;
    import cpu_exec_pkg::*;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alusrc;
        logic [2:0] alufn;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       nia;
        logic       br;
        logic [7:0] aluout;
        logic [7:0] mem_out;
        logic [7:0] wb;
        logic       zero;
        logic       carry;
        logic       ovf;
    } exp_t;

    localparam int W = $bits(exp_t);

    logic         clk;
    logic         rst;
    logic [W-1:0] exp_q[$];
    logic [7:0]   mem_m [256];
    int           errors;
    int           checks;

    cpu_exec_if bus ();

    cpu_exec_unit #(.DMEM_AW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [3:0] op, input logic [2:0] fn,
                                   input logic [7:0] a, input logic [7:0] b, input logic [7:0] im);
        exp_t       e;
        logic [7:0] opb;
        int         ia, ib, sa, sb, r;
        e       = '0;
        e.alufn = 3'b000;
        e.nia   = 1'b1;
        case (op)
            4'h0: begin e.reg_write = 1; e.reg_dst = 1; e.mem_to_reg = 1; e.alufn = fn; end
            4'h1: begin e.reg_write = 1; e.alusrc = 1; e.mem_to_reg = 1; end
            4'h2: begin e.reg_write = 1; e.alusrc = 1; e.mem_read = 1; end
            4'h3: begin e.alusrc = 1; e.mem_write = 1; end
            4'h4: begin e.alufn = 3'b001; e.br = (a == b); end
            4'h5: begin e.alufn = 3'b001; e.br = (a != b); end
            4'h6: e.nia = 1'b0;
            default: ;
        endcase
        opb = e.alusrc ? im : b;
        ia  = int'(a);
        ib  = int'(opb);
        sa  = (ia > 127) ? ia - 256 : ia;
        sb  = (ib > 127) ? ib - 256 : ib;
        case (e.alufn)
            3'b000:  r = ia + ib;
            3'b001:  r = ia - ib;
            3'b010:  r = int'(a & opb);
            3'b011:  r = int'(a | opb);
            3'b100:  r = int'(a ^ opb);
            3'b101:  r = (sa < sb) ? 1 : 0;
            3'b110:  r = ia * (1 << opb[2:0]);
            default: r = ia / (1 << opb[2:0]);
        endcase
        e.aluout  = r[7:0];
        e.mem_out = e.mem_read ? mem_m[e.aluout] : 8'h00;
        e.wb      = e.mem_to_reg ? e.aluout : e.mem_out;
        e.zero    = (e.aluout == 8'h00);
        e.carry   = (e.alufn == 3'b000) ? (ia + ib > 255) :
                    (e.alufn == 3'b001) ? (ia < ib) : 1'b0;
        e.ovf     = (e.alufn == 3'b000) ? ((sa + sb > 127) || (sa + sb < -128)) :
                    (e.alufn == 3'b001) ? ((sa - sb > 127) || (sa - sb < -128)) : 1'b0;
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input string tag, input logic r, input logic [3:0] op, input logic [2:0] fn,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] im);
        exp_t e;
        @(negedge clk);
        rst        = r;
        bus.opcode = op;
        bus.func   = fn;
        bus.ra     = a;
        bus.rb     = b;
        bus.imm    = im;
        exp_q.push_back(W'(model(op, fn, a, b, im)));
        #1;
        e = exp_t'(exp_q.pop_front());
        chk({tag, ".ctrl"}, 32'({bus.reg_dst, bus.reg_write, bus.alusrc, bus.alufn, bus.mem_read,
                                 bus.mem_write, bus.mem_to_reg, bus.nia, bus.br}),
                            32'({e.reg_dst, e.reg_write, e.alusrc, e.alufn, e.mem_read,
                                 e.mem_write, e.mem_to_reg, e.nia, e.br}));
        chk({tag, ".aluout"}, 32'(bus.aluout), 32'(e.aluout));
        chk({tag, ".mem_out"}, 32'(bus.mem_out), 32'(e.mem_out));
        chk({tag, ".wb_data"}, 32'(bus.wb_data), 32'(e.wb));
`ifdef ALU_FLAGS_EN
        chk({tag, ".flags"}, 32'({bus.alu_zero, bus.alu_carry, bus.alu_ovf}),
                             32'({e.zero, e.carry, e.ovf}));
`endif
        // Model the edge that follows: reset clears, otherwise a store lands.
        if (r) begin
            for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        end else if (e.mem_write) begin
            mem_m[e.aluout] = b;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        rst        = 1'b1;
        bus.opcode = 4'hF;
        bus.func   = 3'b000;
        bus.ra     = 8'h00;
        bus.rb     = 8'h00;
        bus.imm    = 8'h00;
        repeat (2) @(posedge clk);

        // Reset state: memory reads back zero.
        step("rst_lw", 1'b0, 4'h2, 3'b000, 8'h00, 8'h00, 8'h37);
        chk("rst_lw.const", 32'(bus.wb_data), 32'h00);

        step("add", 1'b0, 4'h0, 3'b000, 8'h7F, 8'h02, 8'h00);
        chk("add.const", 32'(bus.aluout), 32'h81);
`ifdef ALU_FLAGS_EN
        chk("add.ovf", 32'(bus.alu_ovf), 32'h1);
`endif
        step("sub", 1'b0, 4'h0, 3'b001, 8'h05, 8'h07, 8'h00);
        chk("sub.const", 32'(bus.aluout), 32'hFE);
        step("slt", 1'b0, 4'h0, 3'b101, 8'hFF, 8'h01, 8'h00);
        chk("slt.const", 32'(bus.aluout), 32'h01);
        step("srl", 1'b0, 4'h0, 3'b111, 8'h80, 8'h03, 8'h00);
        chk("srl.const", 32'(bus.aluout), 32'h10);

        step("sw", 1'b0, 4'h3, 3'b000, 8'h10, 8'hA5, 8'h05);
        step("lw", 1'b0, 4'h2, 3'b000, 8'h10, 8'h00, 8'h05);
        chk("lw.const", 32'({bus.mem_out, bus.wb_data, 7'b0, bus.reg_dst}), 32'({8'hA5, 8'hA5, 8'h00}));

        // Read-during-write returns old data, new data next cycle.
        step("rdw_sw", 1'b0, 4'h3, 3'b000, 8'h15, 8'h3C, 8'h00);
        step("rdw_lw", 1'b0, 4'h2, 3'b000, 8'h15, 8'h00, 8'h00);

        step("beq_t", 1'b0, 4'h4, 3'b000, 8'h33, 8'h33, 8'h00);
        chk("beq_t.const", 32'({bus.br, bus.nia}), 32'h3);
        step("beq_f", 1'b0, 4'h4, 3'b000, 8'h33, 8'h34, 8'h00);
        step("bne_t", 1'b0, 4'h5, 3'b000, 8'h33, 8'h34, 8'h00);
        step("bne_f", 1'b0, 4'h5, 3'b000, 8'h77, 8'h77, 8'h00);
        step("j", 1'b0, 4'h6, 3'b010, 8'h12, 8'h34, 8'h56);
        chk("j.const", 32'({bus.nia, bus.reg_write, bus.mem_write}), 32'h0);
        step("nop_f", 1'b0, 4'hF, 3'b111, 8'hAA, 8'h55, 8'h01);
        step("nop_7", 1'b0, 4'h7, 3'b001, 8'h01, 8'h02, 8'h03);
        step("addi", 1'b0, 4'h1, 3'b000, 8'hF0, 8'h00, 8'h20);

        // Reset beats a simultaneous store and clears earlier data.
        step("pre_sw", 1'b0, 4'h3, 3'b000, 8'h20, 8'h55, 8'h00);
        step("pre_lw", 1'b0, 4'h2, 3'b000, 8'h20, 8'h00, 8'h00);
        step("rst_sw", 1'b1, 4'h3, 3'b000, 8'h20, 8'h99, 8'h00);
        step("post_lw", 1'b0, 4'h2, 3'b000, 8'h20, 8'h00, 8'h00);
        chk("post_lw.const", 32'(bus.mem_out), 32'h00);
        step("post_lw2", 1'b0, 4'h2, 3'b000, 8'h10, 8'h00, 8'h05);

        for (int n = 0; n < 40; n++) begin
            step("rnd_r", 1'b0, 4'h0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'h00);
        end
        for (int n = 0; n < 30; n++) begin
            step("rnd_mem", 1'b0, 4'($urandom_range(1, 3)), 3'b000, 8'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 7)));
        end
        for (int n = 0; n < 10; n++) begin
            step("rnd_br", 1'b0, 4'($urandom_range(4, 5)), 3'b000, 8'($urandom_range(0, 3)),
                 8'($urandom_range(0, 3)), 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_exec_unit.md
Name: cpu_exec_unit

Overview:
Execute/memory slice of the 8-bit single-cycle CPU. It combines three functions:
- instruction control decode;
- the 8-bit ALU with branch compare;
- a 256x8 data memory with writeback select.

It sits between the decoder/regfile and the PC logic. It consumes opcode, func, register operands and immediate. It produces control strobes, the branch/next-address flags and the register writeback value.

Parameters:
DATA_W, 8, datapath width (only 8 supported)
DMEM_AW, 8, data memory address width; depth = 2**DMEM_AW

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  4  instruction opcode
func  in  3  R-type function field
ra  in  8  register A read data
rb  in  8  register B read data
imm  in  8  immediate
reg_dst  out  1  1 = write rd, 0 = write rb
reg_write  out  1  regfile write enable
alusrc  out  1  1 = ALU operand B is imm, 0 = rb
alufn  out  3  ALU function
mem_read  out  1  data memory read enable
mem_write  out  1  data memory write enable
mem_to_reg  out  1  1 = writeback from ALU, 0 = from memory
nia  out  1  0 = jump (PC += addr), 1 = sequential/branch
br  out  1  branch taken
aluout  out  8  ALU result; also memory address
mem_out  out  8  memory read data
wb_data  out  8  register writeback value

Behaviour:
Decode is combinational. Opcode map:
- 0x0 R-type: reg_write=1, reg_dst=1, alusrc=0, mem_to_reg=1, alufn=func.
- 0x1 ADDI: reg_write=1, reg_dst=0, alusrc=1, alufn=ADD, mem_to_reg=1.
- 0x2 LW: reg_write=1, reg_dst=0, alusrc=1, alufn=ADD, mem_read=1, mem_to_reg=0.
- 0x3 SW: alusrc=1, alufn=ADD, mem_write=1; store data = rb.
- 0x4 BEQ: alusrc=0, alufn=SUB; br = (ra==rb).
- 0x5 BNE: alusrc=0, alufn=SUB; br = (ra!=rb).
- 0x6 J: nia=0.
- All other opcodes are NOP: every strobe 0, alufn=ADD, nia=1, br=0.
- nia=1 for every opcode except J. br=0 for every opcode except BEQ/BNE.

ALU is combinational with operand B = alusrc ? imm : rb. alufn encoding:
- 000 ADD, mod 256.
- 001 SUB, mod 256.
- 010 AND.
- 011 OR.
- 100 XOR.
- 101 SLT: signed; result 0x01 or 0x00.
- 110 SLL by B[2:0].
- 111 SRL (logical) by B[2:0].

Data memory:
- 256x8, address = aluout.
- Write is synchronous: on posedge clk with mem_write=1, mem[aluout] <= rb.
- Read is combinational: mem_out = mem[aluout] when mem_read=1, else 0x00.
- Read-during-write to the same address returns the old data; new data is visible the next cycle.
- rst=1 at posedge clk clears all 256 locations to 0x00; rst has priority over a simultaneous write.
- Decode/ALU outputs are purely combinational and unaffected by rst.

wb_data = mem_to_reg ? aluout : mem_out.

Optional Feature:
ALU_FLAGS_EN
- Defined: adds three outputs, each 1 bit:
  - alu_zero: aluout==0.
  - alu_carry: carry out of ADD, or borrow of SUB.
  - alu_ovf: signed overflow of ADD/SUB.
- alu_carry and alu_ovf are 0 for all other alufn values.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package cpu_exec_pkg holds:
  - opcode constants OP_RTYPE..OP_J;
  - alufn constants ALU_ADD..ALU_SRL;
  - DATA_W.
- Natural sub-module: cpu_exec_alu, covering the ALU plus branch compare and optional flags.
- Decode and memory stay in the top.

Test Plan:
- R-type ADD: opcode=0x0, func=000, ra=0x7F, rb=0x02 -> aluout=0x81, reg_write=1, reg_dst=1, wb_data=0x81; with ALU_FLAGS_EN, alu_ovf=1.
- R-type SUB, SLT and SRL:
  - SUB: ra=0x05, rb=0x07 -> aluout=0xFE.
  - SLT: ra=0xFF, rb=0x01 -> aluout=0x01.
  - SRL: ra=0x80, rb=0x03 -> aluout=0x10.
- SW then LW:
  - SW: opcode=0x3, ra=0x10, imm=0x05, rb=0xA5 -> at clk edge mem[0x15] becomes 0xA5.
  - LW in the next cycle with the same ra/imm -> mem_out=0xA5, wb_data=0xA5, reg_dst=0.
- Branches:
  - BEQ ra=rb=0x33 -> br=1, nia=1.
  - BEQ ra=0x33, rb=0x34 -> br=0.
  - BNE ra=0x33, rb=0x34 -> br=1.
- J (0x6) -> nia=0, reg_write=0, mem_write=0. Opcode 0xF -> all strobes 0, nia=1, br=0.
- Reset:
  - Write mem[0x20]=0x55, then assert rst together with mem_write=1 for one cycle -> LW of 0x20 returns 0x00.
  - mem_read=0 -> mem_out=0x00.
